// File: rtl/spi_read_tracker_pkg.sv
// Shared definitions for the SPI read tracker: opcodes and FSM state encoding.
package spi_read_tracker_pkg;

   localparam logic [7:0] OPC_READ      = 8'h03;
   localparam logic [7:0] OPC_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DUMMY = 3'd3,
      ST_DATA  = 3'd4,
      ST_SKIP  = 3'd5
   } state_e;

endpackage

// File: rtl/spi_record_fifo.sv
// Record FIFO: power-of-two depth, head exposed combinationally, zero when empty.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module spi_record_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic             dropped,
   output logic [WIDTH-1:0] head_data
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             full, do_push, do_pop;

   assign valid     = (count_q != '0);
   assign full      = (count_q == (PW+1)'(DEPTH));
   assign do_pop    = pop && valid;
   assign do_push   = push && (!full || do_pop);
   assign dropped   = push && !do_push;
   assign head_data = valid ? mem_q[rd_ptr_q] : '0;

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
   end

   // Pointer and occupancy registers.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge mclk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_read_tracker.sv
// Tracks SPI flash read transactions and queues {opcode, addr, len, sat} records.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | chip select high, strobes ignored
// ST_CMD   | waiting for the opcode byte
// ST_ADDR  | shifting in address bytes, MSB first
// ST_DUMMY | discarding the single fast-read dummy byte
// ST_DATA  | counting data bytes until chip select rises
// ST_SKIP  | non-read opcode, ignoring bytes until chip select rises
module spi_read_tracker
   import spi_read_tracker_pkg::*;
#(
   parameter int ADDR_BYTES  = 3,
   parameter int LEN_BITS    = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int MONITOR_ALL = 0
) (
   input  logic                    mclk,
   input  logic                    reset,
   input  logic                    spi_cs,
   input  logic                    spi_rx_strobe,
   input  logic [7:0]              spi_rx_data,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [7:0]              rec_opcode,
   output logic [8*ADDR_BYTES-1:0] rec_addr,
   output logic [LEN_BITS-1:0]     rec_len,
   output logic                    rec_sat,
   output logic [7:0]              drop_count,
   output logic                    busy
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int RW = 8 + AW + LEN_BITS + 1;

   logic [2:0]          cs_sync_q, cs_sync_d;
   state_e              state_q, state_d;
   logic                dummy_q, dummy_d;
   logic [2:0]          byte_cnt_q, byte_cnt_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic                sat_q, sat_d;
   logic [7:0]          drop_count_q, drop_count_d;
   logic                cs_fall, cs_rise;
   logic                push, fifo_dropped;
   logic [RW-1:0]       push_data, head_data;

   assign cs_sync_d = {cs_sync_q[1:0], spi_cs};
   assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
   assign cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];

   // Transaction FSM: CS edges close/open transactions and take priority over strobes.
   always_comb begin
      state_d    = state_q;
      dummy_d    = dummy_q;
      byte_cnt_d = byte_cnt_q;
      opcode_d   = opcode_q;
      addr_d     = addr_q;
      len_d      = len_q;
      sat_d      = sat_q;
      push       = 1'b0;
      push_data  = {opcode_q, addr_q, len_q, sat_q};
      if (cs_rise || cs_fall) begin
         if (state_q == ST_DATA) begin
            push = 1'b1;
         end else if (state_q == ST_SKIP && MONITOR_ALL != 0) begin
            push      = 1'b1;
            push_data = {opcode_q, {(RW-8){1'b0}}};
         end
         state_d = ST_IDLE;
         if (cs_fall) begin
            state_d    = ST_CMD;
            dummy_d    = 1'b0;
            byte_cnt_d = '0;
            opcode_d   = '0;
            addr_d     = '0;
            len_d      = '0;
            sat_d      = 1'b0;
         end
      end else if (spi_rx_strobe) begin
         case (state_q)
            ST_CMD: begin
               opcode_d = spi_rx_data;
               if (spi_rx_data == OPC_READ) begin
                  state_d = ST_ADDR;
               end else if (spi_rx_data == OPC_FAST_READ) begin
                  state_d = ST_ADDR;
                  dummy_d = 1'b1;
               end else begin
                  state_d = ST_SKIP;
               end
            end
            ST_ADDR: begin
               addr_d = {addr_q[AW-9:0], spi_rx_data};
               if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
                  state_d = dummy_q ? ST_DUMMY : ST_DATA;
               end else begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
               end
            end
            ST_DUMMY: state_d = ST_DATA;
            ST_DATA: begin
               if (&len_q) begin
                  sat_d = 1'b1;
               end else begin
                  len_d = len_q + LEN_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Lost-record counter, sticks at 255.
   always_comb begin
      drop_count_d = drop_count_q;
      if (fifo_dropped && drop_count_q != 8'hFF) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   // State and synchronizer registers; synchronizer resets to CS idle (high).
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         cs_sync_q    <= 3'b111;
         state_q      <= ST_IDLE;
         dummy_q      <= 1'b0;
         byte_cnt_q   <= '0;
         opcode_q     <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         sat_q        <= 1'b0;
         drop_count_q <= '0;
      end else begin
         cs_sync_q    <= cs_sync_d;
         state_q      <= state_d;
         dummy_q      <= dummy_d;
         byte_cnt_q   <= byte_cnt_d;
         opcode_q     <= opcode_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         sat_q        <= sat_d;
         drop_count_q <= drop_count_d;
      end
   end

   spi_record_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .mclk      (mclk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (rec_ready),
      .valid     (rec_valid),
      .dropped   (fifo_dropped),
      .head_data (head_data)
   );

   assign rec_opcode = head_data[RW-1 -: 8];
   assign rec_addr   = head_data[RW-9 -: AW];
   assign rec_len    = head_data[LEN_BITS:1];
   assign rec_sat    = head_data[0];
   assign drop_count = drop_count_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_read_tracker.sv
// Bench for spi_read_tracker: three configurations driven independently.
// dut 0: defaults; dut 1: ADDR_BYTES=4, LEN_BITS=4; dut 2: MONITOR_ALL=1.
module tb_spi_read_tracker;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [15:0] len;
      logic        sat;
   } rec_t;

   typedef struct {
      int          dut;
      logic [7:0]  op;
      logic [31:0] addr;
      int          naddr;
      int          ndummy;
      int          ndata;
      bit          exp_rec;
      rec_t        exp;
   } vec_t;

   logic       mclk = 1'b0;
   logic       reset;
   logic       cs  [3];
   logic       stb [3];
   logic [7:0] dat [3];
   logic       rdy [3];

   logic        a_valid, a_sat, a_busy;
   logic [7:0]  a_op, a_drop;
   logic [23:0] a_addr;
   logic [15:0] a_len;
   logic        b_valid, b_sat, b_busy;
   logic [7:0]  b_op, b_drop;
   logic [31:0] b_addr;
   logic [3:0]  b_len;
   logic        c_valid, c_sat, c_busy;
   logic [7:0]  c_op, c_drop;
   logic [23:0] c_addr;
   logic [15:0] c_len;

   int   n_vec  = 0;
   int   n_miss = 0;
   rec_t exp_q0 [$];
   rec_t exp_q1 [$];
   rec_t exp_q2 [$];
   vec_t vecs [11];

   always #5 mclk = ~mclk;

   spi_read_tracker u_a (
      .mclk(mclk), .reset(reset), .spi_cs(cs[0]), .spi_rx_strobe(stb[0]),
      .spi_rx_data(dat[0]), .rec_valid(a_valid), .rec_ready(rdy[0]),
      .rec_opcode(a_op), .rec_addr(a_addr), .rec_len(a_len), .rec_sat(a_sat),
      .drop_count(a_drop), .busy(a_busy)
   );

   spi_read_tracker #(.ADDR_BYTES(4), .LEN_BITS(4)) u_b (
      .mclk(mclk), .reset(reset), .spi_cs(cs[1]), .spi_rx_strobe(stb[1]),
      .spi_rx_data(dat[1]), .rec_valid(b_valid), .rec_ready(rdy[1]),
      .rec_opcode(b_op), .rec_addr(b_addr), .rec_len(b_len), .rec_sat(b_sat),
      .drop_count(b_drop), .busy(b_busy)
   );

   spi_read_tracker #(.MONITOR_ALL(1)) u_c (
      .mclk(mclk), .reset(reset), .spi_cs(cs[2]), .spi_rx_strobe(stb[2]),
      .spi_rx_data(dat[2]), .rec_valid(c_valid), .rec_ready(rdy[2]),
      .rec_opcode(c_op), .rec_addr(c_addr), .rec_len(c_len), .rec_sat(c_sat),
      .drop_count(c_drop), .busy(c_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic rec_t mk_rec(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [15:0] len, input logic sat);
      rec_t r;
      r.op = op; r.addr = addr; r.len = len; r.sat = sat;
      return r;
   endfunction

   function automatic vec_t mk_vec(input int dut, input logic [7:0] op, input logic [31:0] addr,
                                   input int naddr, input int ndummy, input int ndata,
                                   input bit exp_rec, input rec_t exp);
      vec_t v;
      v.dut = dut; v.op = op; v.addr = addr; v.naddr = naddr; v.ndummy = ndummy;
      v.ndata = ndata; v.exp_rec = exp_rec; v.exp = exp;
      return v;
   endfunction

   function automatic rec_t act_rec(input int d);
      rec_t r;
      case (d)
         0:       r = {a_op, 8'h00, a_addr, a_len, a_sat};
         1:       r = {b_op, b_addr, 12'h000, b_len, b_sat};
         default: r = {c_op, 8'h00, c_addr, c_len, c_sat};
      endcase
      return r;
   endfunction

   task automatic push_exp(input int d, input rec_t r);
      case (d)
         0:       exp_q0.push_back(r);
         1:       exp_q1.push_back(r);
         default: exp_q2.push_back(r);
      endcase
   endtask

   task automatic mon(input int d);
      rec_t e;
      int   sz;
      case (d)
         0:       sz = exp_q0.size();
         1:       sz = exp_q1.size();
         default: sz = exp_q2.size();
      endcase
      if (sz == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL unexpected_rec dut%0d: got %0h, expected no record", d, act_rec(d));
      end else begin
         case (d)
            0:       e = exp_q0.pop_front();
            1:       e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
         endcase
         check($sformatf("rec_dut%0d", d), 64'(act_rec(d)), 64'(e));
      end
   endtask

   // Scoreboard side: compare each record as the consumer accepts it.
   always @(negedge mclk) begin
      if (reset === 1'b0) begin
         if (a_valid && rdy[0]) mon(0);
         if (b_valid && rdy[1]) mon(1);
         if (c_valid && rdy[2]) mon(2);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   // Leaves the caller just past the first edge where the FSM is in CMD.
   // Optionally pulses a strobe in the edge-detect cycle, which must be ignored.
   task automatic cs_fall(input int d, input bit edge_stb, input logic [7:0] b);
      cs[d] = 1'b0;
      tick(2);
      if (edge_stb) begin
         stb[d] = 1'b1;
         dat[d] = b;
      end
      tick(1);
      stb[d] = 1'b0;
      tick(1);
   endtask

   task automatic send_byte(input int d, input logic [7:0] b);
      stb[d] = 1'b1;
      dat[d] = b;
      tick(1);
      stb[d] = 1'b0;
      tick(1);
   endtask

   task automatic cs_rise(input int d);
      cs[d] = 1'b1;
      tick(6);
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] sh;
      cs_fall(v.dut, 1'b0, 8'h00);
      send_byte(v.dut, v.op);
      for (int j = 0; j < v.naddr; j++) begin
         sh = v.addr >> (8 * (v.naddr - 1 - j));
         send_byte(v.dut, sh[7:0]);
      end
      for (int j = 0; j < v.ndummy; j++) send_byte(v.dut, 8'hFF);
      for (int j = 0; j < v.ndata; j++) send_byte(v.dut, 8'(j + 48));
      if (v.exp_rec) push_exp(v.dut, v.exp);
      cs_rise(v.dut);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t none;
      none = mk_rec(8'h00, 32'h0, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cs[i] = 1'b1; stb[i] = 1'b0; dat[i] = 8'h00; rdy[i] = 1'b1;
      end
      reset = 1'b1;

      vecs[0]  = mk_vec(0, 8'h03, 32'h00123456, 3, 0, 5,  1, mk_rec(8'h03, 32'h00123456, 16'd5, 1'b0));
      vecs[1]  = mk_vec(0, 8'h0B, 32'h00001000, 3, 1, 2,  1, mk_rec(8'h0B, 32'h00001000, 16'd2, 1'b0));
      vecs[2]  = mk_vec(1, 8'h03, 32'hDEADBEEF, 4, 0, 20, 1, mk_rec(8'h03, 32'hDEADBEEF, 16'd15, 1'b1));
      vecs[3]  = mk_vec(1, 8'h03, 32'h01020304, 4, 0, 3,  1, mk_rec(8'h03, 32'h01020304, 16'd3, 1'b0));
      vecs[4]  = mk_vec(0, 8'h05, 32'h0,        0, 0, 3,  0, none);
      vecs[5]  = mk_vec(2, 8'h05, 32'h0,        0, 0, 2,  1, mk_rec(8'h05, 32'h0, 16'd0, 1'b0));
      vecs[6]  = mk_vec(0, 8'h03, 32'h00001234, 2, 0, 0,  0, none);
      vecs[7]  = mk_vec(0, 8'h0B, 32'h00ABCDEF, 3, 0, 0,  0, none);
      vecs[8]  = mk_vec(2, 8'h03, 32'h00FFFFFF, 3, 0, 1,  1, mk_rec(8'h03, 32'h00FFFFFF, 16'd1, 1'b0));
      vecs[9]  = mk_vec(0, 8'h03, 32'h00000000, 3, 0, 0,  1, mk_rec(8'h03, 32'h0, 16'd0, 1'b0));
      vecs[10] = mk_vec(2, 8'h0B, 32'h000A0B0C, 3, 1, 0,  1, mk_rec(8'h0B, 32'h000A0B0C, 16'd0, 1'b0));

      tick(3);
      check("rst_valid",  64'(a_valid), 64'd0);
      check("rst_busy",   64'(a_busy),  64'd0);
      check("rst_drop",   64'(a_drop),  64'd0);
      check("rst_opcode", 64'(a_op),    64'd0);
      check("rst_addr",   64'(a_addr),  64'd0);
      check("rst_len",    64'(a_len),   64'd0);
      check("rst_sat",    64'(a_sat),   64'd0);
      reset = 1'b0;
      tick(2);

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i]);
         tick(2);
      end

      // Strobes with CS idle must not open a transaction.
      send_byte(0, 8'h03);
      send_byte(0, 8'h00);
      check("idle_strobe_busy", 64'(a_busy), 64'd0);
      tick(4);
      check("idle_strobe_valid", 64'(a_valid), 64'd0);

      // Strobe in the CS-fall detect cycle is dropped, so 0x05 becomes the opcode.
      cs_fall(0, 1'b1, 8'h03);
      send_byte(0, 8'h05);
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      send_byte(0, 8'h33);
      send_byte(0, 8'h44);
      check("edge_stb_busy", 64'(a_busy), 64'd1);
      cs_rise(0);
      check("edge_stb_valid", 64'(a_valid), 64'd0);

      // Back-to-back transactions separated by a one-cycle CS high pulse.
      cs_fall(0, 1'b0, 8'h00);
      send_byte(0, 8'h03);
      send_byte(0, 8'hAA); send_byte(0, 8'hBB); send_byte(0, 8'hCC);
      send_byte(0, 8'h01); send_byte(0, 8'h02);
      push_exp(0, mk_rec(8'h03, 32'h00AABBCC, 16'd2, 1'b0));
      cs[0] = 1'b1;
      tick(1);
      cs[0] = 1'b0;
      tick(4);
      send_byte(0, 8'h03);
      send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h01);
      send_byte(0, 8'h77);
      push_exp(0, mk_rec(8'h03, 32'h00000001, 16'd1, 1'b0));
      cs_rise(0);
      tick(2);

      // Six reads into a depth-4 FIFO with the consumer stalled.
      rdy[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cs_fall(0, 1'b0, 8'h00);
         send_byte(0, 8'h03);
         send_byte(0, 8'h00); send_byte(0, 8'h50); send_byte(0, 8'(k));
         for (int j = 0; j < k + 1; j++) send_byte(0, 8'(j));
         if (k < 4) push_exp(0, mk_rec(8'h03, 32'h00005000 + 32'(k), 16'(k + 1), 1'b0));
         cs_rise(0);
      end
      check("full_drop_count", 64'(a_drop),  64'd2);
      check("full_valid",      64'(a_valid), 64'd1);
      check("full_head_addr",  64'(a_addr),  64'h5000);
      check("full_head_len",   64'(a_len),   64'd1);
      tick(3);
      check("stall_head_addr", 64'(a_addr),  64'h5000);
      rdy[0] = 1'b1;
      tick(8);
      check("drained_valid", 64'(a_valid), 64'd0);

      // Reset while in DATA with two records queued.
      rdy[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cs_fall(0, 1'b0, 8'h00);
         send_byte(0, 8'h03);
         send_byte(0, 8'h0F); send_byte(0, 8'h0E); send_byte(0, 8'(k));
         send_byte(0, 8'h99);
         cs_rise(0);
      end
      cs_fall(0, 1'b0, 8'h00);
      send_byte(0, 8'h03);
      send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03);
      send_byte(0, 8'h10); send_byte(0, 8'h11);
      check("pre_rst_busy",  64'(a_busy),  64'd1);
      check("pre_rst_valid", 64'(a_valid), 64'd1);
      check("pre_rst_drop",  64'(a_drop),  64'd2);
      reset = 1'b1;
      cs[0] = 1'b1;
      @(negedge mclk);
      check("mid_rst_valid",  64'(a_valid), 64'd0);
      check("mid_rst_busy",   64'(a_busy),  64'd0);
      check("mid_rst_drop",   64'(a_drop),  64'd0);
      check("mid_rst_opcode", 64'(a_op),    64'd0);
      tick(2);
      reset = 1'b0;
      rdy[0] = 1'b1;
      tick(8);
      check("post_rst_valid", 64'(a_valid), 64'd0);
      check("post_rst_busy",  64'(a_busy),  64'd0);
      run_vec(mk_vec(0, 8'h03, 32'h00654321, 3, 0, 4, 1, mk_rec(8'h03, 32'h00654321, 16'd4, 1'b0)));

      tick(10);
      check("leftover_dut0", 64'(exp_q0.size()), 64'd0);
      check("leftover_dut1", 64'(exp_q1.size()), 64'd0);
      check("leftover_dut2", 64'(exp_q2.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/spi_read_tracker.md
SPI_READ_TRACKER -- requirements
Module: spi_read_tracker

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 3, address bytes after opcode (legal values 3 or 4).
REQ-002 SHALL have parameter LEN_BITS, default 16, width of the data-byte length field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, record FIFO entries (power of two, at least 2).
REQ-004 SHALL have parameter MONITOR_ALL, default 0; 1 = also record non-read opcodes.
REQ-005 SHALL have port mclk  in  1  sole clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port spi_cs  in  1  raw asynchronous chip select, active low.
REQ-008 SHALL have port spi_rx_strobe  in  1  one-mclk pulse marking a received SPI byte.
REQ-009 SHALL have port spi_rx_data  in  8  received byte, valid with strobe.
REQ-010 SHALL have port rec_valid  out  1  record available at FIFO head.
REQ-011 SHALL have port rec_ready  in  1  consumer accepts head record when high with rec_valid.
REQ-012 SHALL have port rec_opcode  out  8  opcode of the head record.
REQ-013 SHALL have port rec_addr  out  8*ADDR_BYTES  start address of the head record, first byte received = MSB.
REQ-014 SHALL have port rec_len  out  LEN_BITS  data bytes seen, saturating.
REQ-015 SHALL have port rec_sat  out  1  rec_len saturated.
REQ-016 SHALL have port drop_count  out  8  records lost to full FIFO, saturating at 255.
REQ-017 SHALL have port busy  out  1  a transaction is open (state other than IDLE).

Function
REQ-018 SHALL pass spi_cs through a 3-flop synchronizer; edges are detected on the last two stages.
REQ-019 SHALL treat a synchronized falling edge as transaction start: state becomes CMD, byte counter and length clear.
REQ-020 SHALL use states IDLE, CMD, ADDR, DUMMY, DATA, SKIP.
REQ-021 SHALL, in CMD on strobe, latch the opcode: 0x03 goes to ADDR; 0x0B goes to ADDR with the dummy flag set; any other opcode goes to SKIP.
REQ-022 SHALL, in ADDR, shift in ADDR_BYTES bytes MSB-first, then go to DUMMY if the dummy flag is set, else DATA.
REQ-023 SHALL, in DUMMY, discard exactly one byte, then go to DATA.
REQ-024 SHALL, in DATA, increment the length on each strobe, saturating at 2^LEN_BITS-1 and setting the sat flag.
REQ-025 SHALL, on a synchronized rising edge in DATA, write {opcode, addr, len, sat} to the FIFO in the detect cycle, then return to IDLE.
REQ-026 SHALL, on a rising edge in SKIP, write {opcode, 0, 0, 0} only if MONITOR_ALL=1 and an opcode was received, then return to IDLE.
REQ-027 SHALL discard a transaction ending in CMD, ADDR or DUMMY with no record written.
REQ-028 SHALL let a CS edge win over a strobe in the same cycle; that strobe is ignored.
REQ-029 SHALL, on a falling edge while not IDLE (missed rise), first close the open transaction per REQ-025 to REQ-027, then start a new one.
REQ-030 SHALL, on a write to a full FIFO, drop the new record, keep the stored ones, and increment drop_count.
REQ-031 SHALL assert rec_valid on the cycle after a write into an empty FIFO; the record fields SHALL be stable while rec_valid && !rec_ready.
REQ-032 SHALL pop on rec_valid && rec_ready; a simultaneous push and pop on a full FIFO SHALL succeed with no drop.
REQ-033 SHALL generate no record and no state change from strobes in IDLE.

Reset
REQ-034 SHALL, on reset: state=IDLE, FIFO empty, rec_valid=0, rec_opcode/rec_addr/rec_len/rec_sat=0, drop_count=0, busy=0, synchronizer flops=1 (CS idle).
REQ-035 SHALL abandon any open transaction on reset mid-operation, with no record written.

Structure
REQ-036 SHALL place the opcode constants (0x03, 0x0B) and state encodings in the shared definitions header.
REQ-037 SHALL implement the record FIFO as one sub-module, spi_record_fifo, parametrised in width and depth.

Verification
REQ-038 SHALL cover: CS low, 03 12 34 56, then 5 data bytes, CS high -> one record {03, 0x123456, 5, sat=0}.
REQ-039 SHALL cover: 0B 00 10 00 (dummy) AA BB -> record {0B, 0x001000, 2}; the dummy byte is not counted.
REQ-040 SHALL cover: ADDR_BYTES=4, LEN_BITS=4, 03 DE AD BE EF plus 20 data bytes -> {03, 0xDEADBEEF, 15, sat=1}.
REQ-041 SHALL cover: rec_ready=0, 6 reads with FIFO_DEPTH=4 -> 4 records retained in order, drop_count=2.
REQ-042 SHALL cover: opcode 05 with MONITOR_ALL=0 -> no record; with MONITOR_ALL=1 -> {05, 0, 0}; CS rising after only 2 address bytes -> no record.
REQ-043 SHALL cover: reset asserted in DATA with 2 records queued -> rec_valid=0 next cycle, busy=0, drop_count=0.
